dmi_host_fsm: RTL and testbench
===============================

Name: dmi_host_fsm

Overview:
- DTM-side initiator of the DMI link. It is the requester end that drives the debug module's dmi_req/dmi_resp responder.
- Accepts 41-bit access words latched by the JTAG DR update path and issues them as valid/ready DMI requests.
- Collects the response and presents it for the next DR capture.
- Maintains the sticky DMI error status: busy / op-failed.

Parameters:
None. Widths are fixed by dm::dmi_req_t (41 bits) and dm::dmi_resp_t (34 bits).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
update_i  in  1  single-cycle pulse: DR update with new access word
update_req_i  in  41  dm::dmi_req_t {addr[6:0], op[1:0], data[31:0]}, valid when update_i=1
capture_i  in  1  single-cycle pulse: DR capture
dmireset_i  in  1  clear sticky error (dtmcs.dmireset)
dmihardreset_i  in  1  abort outstanding access, clear error
capture_data_o  out  41  {addr[6:0], data[31:0], status[1:0]} for DR shift-out
dmi_req_o  out  41  dm::dmi_req_t to DM
dmi_req_valid_o  out  1  request valid
dmi_req_ready_i  in  1  DM accepts request
dmi_resp_i  in  34  dm::dmi_resp_t {data[31:0], resp[1:0]}
dmi_resp_valid_i  in  1  response valid
dmi_resp_ready_o  out  1  host accepts response
error_o  out  2  sticky dmi_error_e, mirrored into dtmcs.dmistat

Behaviour:
- Reset values: state Idle; addr_q, data_q = 0; error_q = DMINoError (0); all outputs 0.
- States (dm::dmi_host_state_e): Idle, Read, WaitReadValid, Write, WaitWriteValid.
- Idle:
  - update_i=1 and error_q==NoError: latch addr_q/data_q from update_req_i.
  - op==DTM_READ -> Read. op==DTM_WRITE -> Write. op==DTM_NOP -> stay Idle, no request.
  - update_i=1 with error_q!=NoError: ignored, nothing latched.
- Read / Write:
  - dmi_req_valid_o=1.
  - dmi_req_o = {addr_q, op, data_q}; data_q is a don't-care for reads but is driven as held.
  - Valid stays high, payload stable, until dmi_req_ready_i. Then -> WaitReadValid / WaitWriteValid.
- WaitReadValid / WaitWriteValid:
  - dmi_resp_ready_o=1.
  - On dmi_resp_valid_i: -> Idle.
  - Read only: data_q <= dmi_resp_i.data.
  - If resp != DTM_SUCCESS and error_q==NoError: error_q <= DMIOpFailed (2).
- Latency:
  - update in cycle N -> dmi_req_valid_o in N+1.
  - With ready/resp_valid asserted immediately: request accepted N+1, response consumed N+2, back in Idle at N+3.
- Busy detection: update_i or capture_i while state != Idle and error_q==NoError -> error_q <= DMIBusy (3).
  - Access in flight is NOT aborted; it completes normally.
  - The update word is discarded.
- capture_data_o:
  - = {addr_q, data_q, status}.
  - status = DMIBusy if state != Idle at capture, else error_q.
  - Combinational from current state/regs.
- Sticky error: once non-zero, holds until dmireset_i or dmihardreset_i. The first error wins; a later error does not overwrite.
- dmireset_i: error_q <= NoError next cycle; state unaffected.
  - Same cycle as update_i: the update is gated by error_q before the clear, so it is ignored if error_q was set.
  - Same cycle as a new busy condition: the clear wins.
- dmihardreset_i: forces Idle, clears error_q, deasserts valid/ready next cycle. Priority over all other events. addr_q/data_q are kept.
- Async reset mid-access: immediate return to reset values; no completion.
- error_o = error_q.

Decomposition:
- dm package additions:
  - dmi_host_state_e (3-bit enum above).
  - dmi_error_e {DMINoError=0, DMIReservedError=1, DMIOpFailed=2, DMIBusy=3}.
  - DTM_SUCCESS reused.
- Single flat module. No sub-module; the FSM and three registers are smaller than any useful split.

Test Plan:
1. Read, DM ready/resp immediate:
   - Stimulus: update {addr=0x11, op=READ}; resp {data=0x0040_0382, resp=0}.
   - Response: valid high for 1 cycle with req.addr=0x11; back to Idle at N+3.
   - Capture gives {0x11, 0x0040_0382, 2'b00}.
2. Write with back-pressure:
   - Stimulus: update {addr=0x04, op=WRITE, data=0xDEAD_BEEF}; ready held low 5 cycles.
   - Response: valid and payload stable for all 5 cycles; resp accepted; error_o=0.
3. Busy:
   - Stimulus: DM withholds resp_valid; capture_i, then update {op=WRITE, addr=0x10}.
   - Response: capture status=3; error_o=3; no second request issued.
   - Then dmireset_i -> error_o=0 next cycle.
4. Op failed:
   - Stimulus: read returns resp=2'b10; then a new update.
   - Response: error_o=2; subsequent update ignored (no valid) until dmireset_i.
5. NOP:
   - Stimulus: update op=NOP.
   - Response: no dmi_req_valid_o; capture status 0.
6. Hard reset:
   - Stimulus: dmihardreset_i in WaitReadValid with error_o=3.
   - Response: Idle and error_o=0 next cycle; resp_ready low.
   - Async rst_ni low mid-Read -> all outputs 0 immediately.

Source files
------------

// File: rtl/dmi_host_fsm_pkg.sv
// Types and constants shared by the DTM-side DMI initiator: request/response
// layouts, DTM op codes, host FSM state encoding and the sticky error code.
package dmi_host_fsm_pkg;

  localparam int unsigned DmiAddrWidth = 7;
  localparam int unsigned DmiDataWidth = 32;
  localparam int unsigned DmiOpWidth   = 2;
  localparam int unsigned DmiReqWidth  = DmiAddrWidth + DmiOpWidth + DmiDataWidth;
  localparam int unsigned DmiRespWidth = DmiDataWidth + 2;
  localparam int unsigned CaptureWidth = DmiAddrWidth + DmiDataWidth + 2;

  typedef logic [DmiOpWidth-1:0] dtm_op_t;

  localparam dtm_op_t DTM_NOP   = 2'h0;
  localparam dtm_op_t DTM_READ  = 2'h1;
  localparam dtm_op_t DTM_WRITE = 2'h2;

  // Response code returned by the DM for a completed access.
  localparam logic [1:0] DTM_SUCCESS = 2'h0;

  typedef struct packed {
    logic [DmiAddrWidth-1:0] addr;
    dtm_op_t                 op;
    logic [DmiDataWidth-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [DmiDataWidth-1:0] data;
    logic [1:0]              resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    DMINoError       = 2'h0,
    DMIReservedError = 2'h1,
    DMIOpFailed      = 2'h2,
    DMIBusy          = 2'h3
  } dmi_error_e;

  // Host FSM state encoding, kept as plain constants for legacy compatibility.
  typedef logic [2:0] dmi_host_state_e;

  localparam dmi_host_state_e Idle           = 3'd0;
  localparam dmi_host_state_e Read           = 3'd1;
  localparam dmi_host_state_e WaitReadValid  = 3'd2;
  localparam dmi_host_state_e Write          = 3'd3;
  localparam dmi_host_state_e WaitWriteValid = 3'd4;

  // Status reported on DR capture: an access still in flight always reads as busy.
  function automatic logic [1:0] capture_status(input dmi_host_state_e state,
                                                input dmi_error_e      error);
    return (state == Idle) ? error : DMIBusy;
  endfunction

endpackage

// File: rtl/dmi_host_fsm.sv
// DTM-side DMI initiator: turns DR-update access words into valid/ready DMI
// requests, collects the response for DR capture and keeps the sticky dmistat.
module dmi_host_fsm
  import dmi_host_fsm_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    update_i,
  input  logic [DmiReqWidth-1:0]  update_req_i,
  input  logic                    capture_i,
  input  logic                    dmireset_i,
  input  logic                    dmihardreset_i,
  output logic [CaptureWidth-1:0] capture_data_o,
  output logic [DmiReqWidth-1:0]  dmi_req_o,
  output logic                    dmi_req_valid_o,
  input  logic                    dmi_req_ready_i,
  input  logic [DmiRespWidth-1:0] dmi_resp_i,
  input  logic                    dmi_resp_valid_i,
  output logic                    dmi_resp_ready_o,
  output logic [1:0]              error_o
);

  dmi_host_state_e         state_q, state_d;
  logic [DmiAddrWidth-1:0] addr_q, addr_d;
  logic [DmiDataWidth-1:0] data_q, data_d;
  dmi_error_e              error_q, error_d;

  dmi_req_t  update_req;
  dmi_resp_t dmi_resp;
  dmi_req_t  dmi_req;
  dtm_op_t   req_op;
  logic      idle;
  logic      no_error;
  logic      resp_failed;

  assign update_req  = update_req_i;
  assign dmi_resp    = dmi_resp_i;
  assign idle        = (state_q == Idle);
  assign no_error    = (error_q == DMINoError);
  assign resp_failed = (dmi_resp.resp != DTM_SUCCESS);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    error_d = error_q;

    unique case (state_q)
      Idle: begin
        // New accesses are refused while a sticky error is pending.
        if (update_i && no_error) begin
          addr_d = update_req.addr;
          data_d = update_req.data;
          if (update_req.op == DTM_READ) begin
            state_d = Read;
          end else if (update_req.op == DTM_WRITE) begin
            state_d = Write;
          end
        end
      end
      Read: begin
        if (dmi_req_ready_i) state_d = WaitReadValid;
      end
      Write: begin
        if (dmi_req_ready_i) state_d = WaitWriteValid;
      end
      WaitReadValid: begin
        if (dmi_resp_valid_i) begin
          state_d = Idle;
          data_d  = dmi_resp.data;
          if (resp_failed && no_error) error_d = DMIOpFailed;
        end
      end
      WaitWriteValid: begin
        if (dmi_resp_valid_i) begin
          state_d = Idle;
          if (resp_failed && no_error) error_d = DMIOpFailed;
        end
      end
      default: state_d = Idle;
    endcase

    // DR traffic during an access is flagged, but the access itself completes.
    if (!idle && (update_i || capture_i) && no_error) error_d = DMIBusy;

    if (dmireset_i) error_d = DMINoError;

    if (dmihardreset_i) begin
      state_d = Idle;
      error_d = DMINoError;
      addr_d  = addr_q;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= DMINoError;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    req_op = DTM_NOP;
    if (state_q == Read) begin
      req_op = DTM_READ;
    end else if (state_q == Write) begin
      req_op = DTM_WRITE;
    end
  end

  assign dmi_req.addr = addr_q;
  assign dmi_req.op   = req_op;
  assign dmi_req.data = data_q;

  assign dmi_req_o        = dmi_req;
  assign dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
  assign dmi_resp_ready_o = (state_q == WaitReadValid) || (state_q == WaitWriteValid);
  assign capture_data_o   = {addr_q, data_q, capture_status(state_q, error_q)};
  assign error_o          = error_q;

endmodule

// File: tb/tb_dmi_host_fsm.sv
// Directed plus randomized bench for dmi_host_fsm; the bench plays both the
// JTAG DR side and the debug module, checking against a transaction-level model.
module tb_dmi_host_fsm;

  localparam logic [1:0] OpNop   = 2'd0;
  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        update_i;
  logic [40:0] update_req_i;
  logic        capture_i;
  logic        dmireset_i;
  logic        dmihardreset_i;
  logic [40:0] capture_data_o;
  logic [40:0] dmi_req_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [33:0] dmi_resp_i;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [1:0]  error_o;

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the DTM-visible registers.
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_err;

  dmi_host_fsm dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .update_i         (update_i),
    .update_req_i     (update_req_i),
    .capture_i        (capture_i),
    .dmireset_i       (dmireset_i),
    .dmihardreset_i   (dmihardreset_i),
    .capture_data_o   (capture_data_o),
    .dmi_req_o        (dmi_req_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_resp_i       (dmi_resp_i),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .error_o          (error_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one access word for a single cycle; returns one cycle after the update edge.
  task automatic do_update(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
    update_i     = 1'b1;
    update_req_i = {addr, op, data};
    step();
    update_i     = 1'b0;
  endtask

  task automatic pulse_dmireset();
    dmireset_i = 1'b1;
    step();
    dmireset_i = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [1:0]  rcode;
    int          dly;

    update_i         = 1'b0;
    update_req_i     = '0;
    capture_i        = 1'b0;
    dmireset_i       = 1'b0;
    dmihardreset_i   = 1'b0;
    dmi_req_ready_i  = 1'b0;
    dmi_resp_i       = '0;
    dmi_resp_valid_i = 1'b0;
    rst_ni           = 1'b1;
    #2 rst_ni = 1'b0;
    #2;
    check("reset_valid", dmi_req_valid_o, 0);
    check("reset_resp_ready", dmi_resp_ready_o, 0);
    check("reset_error", error_o, 0);
    check("reset_capture", capture_data_o, 0);
    check("reset_req", dmi_req_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // Read with an immediately responsive DM.
    dmi_req_ready_i  = 1'b1;
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = {32'h0040_0382, 2'b00};
    do_update(OpRead, 7'h11, 32'h0);
    check("t1_valid_n1", dmi_req_valid_o, 1);
    check("t1_req", dmi_req_o, {7'h11, OpRead, 32'h0});
    step();
    check("t1_valid_n2", dmi_req_valid_o, 0);
    check("t1_resp_ready_n2", dmi_resp_ready_o, 1);
    step();
    check("t1_resp_ready_n3", dmi_resp_ready_o, 0);
    check("t1_capture", capture_data_o, {7'h11, 32'h0040_0382, 2'b00});
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b0;

    // Write with back-pressure on the request channel.
    do_update(OpWrite, 7'h04, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      check("t2_valid_held", dmi_req_valid_o, 1);
      check("t2_req_stable", dmi_req_o, {7'h04, OpWrite, 32'hDEAD_BEEF});
      step();
    end
    dmi_req_ready_i = 1'b1;
    step();
    dmi_req_ready_i = 1'b0;
    check("t2_resp_ready", dmi_resp_ready_o, 1);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = {32'h0, 2'b00};
    step();
    dmi_resp_valid_i = 1'b0;
    check("t2_error", error_o, 0);
    check("t2_back_idle", dmi_resp_ready_o, 0);

    // Busy: capture and update while the read response is withheld.
    dmi_req_ready_i = 1'b1;
    do_update(OpRead, 7'h20, 32'h0);
    step();
    dmi_req_ready_i = 1'b0;
    check("t3_in_wait", dmi_resp_ready_o, 1);
    check("t3_capture_busy", capture_data_o[1:0], 2'd3);
    capture_i = 1'b1;
    step();
    capture_i = 1'b0;
    check("t3_error_busy", error_o, 3);
    do_update(OpWrite, 7'h10, 32'h5555_AAAA);
    check("t3_no_second_req", dmi_req_valid_o, 0);
    check("t3_addr_kept", capture_data_o[40:34], 7'h20);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = {32'h0BAD_F00D, 2'b00};
    step();
    dmi_resp_valid_i = 1'b0;
    check("t3_capture_done", capture_data_o, {7'h20, 32'h0BAD_F00D, 2'd3});
    step();
    check("t3_still_no_req", dmi_req_valid_o, 0);
    pulse_dmireset();
    check("t3_dmireset", error_o, 0);

    // Op failed on a read, then an update that must be ignored.
    dmi_req_ready_i  = 1'b1;
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = {32'h1111_2222, 2'b10};
    do_update(OpRead, 7'h05, 32'h0);
    step();
    step();
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b0;
    check("t4_error_opfailed", error_o, 2);
    do_update(OpWrite, 7'h06, 32'h77);
    check("t4_ignored_n1", dmi_req_valid_o, 0);
    step();
    check("t4_ignored_n2", dmi_req_valid_o, 0);
    check("t4_capture", capture_data_o, {7'h05, 32'h1111_2222, 2'd2});
    pulse_dmireset();
    check("t4_dmireset", error_o, 0);

    // NOP latches the word but issues nothing.
    do_update(OpNop, 7'h33, 32'h1234);
    check("t5_no_valid_n1", dmi_req_valid_o, 0);
    step();
    check("t5_no_valid_n2", dmi_req_valid_o, 0);
    check("t5_capture", capture_data_o, {7'h33, 32'h1234, 2'd0});

    // Hard reset while waiting for a read response with busy pending.
    dmi_req_ready_i = 1'b1;
    do_update(OpRead, 7'h2A, 32'hCAFE);
    step();
    dmi_req_ready_i = 1'b0;
    capture_i = 1'b1;
    step();
    capture_i = 1'b0;
    check("t6_error_busy", error_o, 3);
    check("t6_in_wait", dmi_resp_ready_o, 1);
    dmihardreset_i = 1'b1;
    step();
    dmihardreset_i = 1'b0;
    check("t6_resp_ready_low", dmi_resp_ready_o, 0);
    check("t6_error_clear", error_o, 0);
    check("t6_capture_kept", capture_data_o, {7'h2A, 32'hCAFE, 2'd0});

    // Asynchronous reset in the middle of a read request.
    do_update(OpRead, 7'h15, 32'h99);
    check("t6_read_valid", dmi_req_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_async_valid", dmi_req_valid_o, 0);
    check("t6_async_req", dmi_req_o, 0);
    check("t6_async_capture", capture_data_o, 0);
    check("t6_async_resp_ready", dmi_resp_ready_o, 0);
    check("t6_async_error", error_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // Randomized accesses against the transaction-level model.
    m_addr = '0;
    m_data = '0;
    m_err  = '0;
    for (int it = 0; it < 60; it++) begin
      op   = 2'($urandom_range(0, 2));
      addr = 7'($urandom);
      data = $urandom;
      do_update(op, addr, data);
      if (m_err == 2'd0 && op != OpNop) begin
        m_addr = addr;
        m_data = data;
        dly = $urandom_range(0, 3);
        for (int d = 0; d < dly; d++) begin
          check("rnd_req_held", dmi_req_o, {addr, op, data});
          step();
        end
        check("rnd_req_valid", dmi_req_valid_o, 1);
        check("rnd_req", dmi_req_o, {addr, op, data});
        dmi_req_ready_i = 1'b1;
        step();
        dmi_req_ready_i = 1'b0;
        check("rnd_resp_ready", dmi_resp_ready_o, 1);
        dly = $urandom_range(0, 3);
        for (int d = 0; d < dly; d++) begin
          if ($urandom_range(0, 1) == 1) begin
            check("rnd_capture_busy", capture_data_o[1:0], 2'd3);
            capture_i = 1'b1;
            step();
            capture_i = 1'b0;
            if (m_err == 2'd0) m_err = 2'd3;
          end else begin
            step();
          end
          check("rnd_err_wait", error_o, m_err);
        end
        rdata = $urandom;
        case ($urandom_range(0, 3))
          0, 1:    rcode = 2'b00;
          2:       rcode = 2'b10;
          default: rcode = 2'b11;
        endcase
        dmi_resp_i       = {rdata, rcode};
        dmi_resp_valid_i = 1'b1;
        step();
        dmi_resp_valid_i = 1'b0;
        if (op == OpRead) m_data = rdata;
        if (rcode != 2'b00 && m_err == 2'd0) m_err = 2'd2;
        check("rnd_done_idle", dmi_resp_ready_o, 0);
      end else begin
        if (m_err == 2'd0) begin
          m_addr = addr;
          m_data = data;
        end
        step();
        check("rnd_no_req", dmi_req_valid_o, 0);
      end
      check("rnd_capture", capture_data_o, {m_addr, m_data, m_err});
      check("rnd_error", error_o, m_err);
      if ($urandom_range(0, 2) == 0) begin
        pulse_dmireset();
        m_err = 2'd0;
        check("rnd_dmireset", error_o, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
